// File: rtl/pipelined_control.sv
// pipelined_control: registered MIPS control decoder between IF/ID and ID/EX.
// In: clk, rst_n, instr, instr_valid, flush. Out: stall, ctrl_valid, EX/MEM/WB words, jump/branch/syscall, illegal, halt.
module pipelined_control #(
  parameter int ALUOP_W       = 5,
  parameter int DIV_CYCLES    = 8,
  parameter int SYSCALL_DRAIN = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        instr,
  input  logic               instr_valid,
  input  logic               flush,
  output logic               stall,
  output logic               ctrl_valid,
  output logic [ALUOP_W+1:0] EX_D,
  output logic [1:0]         MEM_D,
  output logic [1:0]         WB_D,
  output logic               Jump,
  output logic               Branch,
  output logic               jr_control,
  output logic               jal_control,
  output logic               syscall_control,
  output logic [2:0]         BranchOp,
  output logic [1:0]         Byte_Warning,
  output logic               illegal,
  output logic               halt
);

  localparam int CMAX = (DIV_CYCLES > SYSCALL_DRAIN) ? DIV_CYCLES : SYSCALL_DRAIN;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0] SYS_LOAD = CW'(SYSCALL_DRAIN - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] F_SLL     = 6'h00;
  localparam logic [5:0] F_SRA     = 6'h03;
  localparam logic [5:0] F_JR      = 6'h08;
  localparam logic [5:0] F_MOVZ    = 6'h0A;
  localparam logic [5:0] F_SYSCALL = 6'h0C;
  localparam logic [5:0] F_BREAK   = 6'h0D;
  localparam logic [5:0] F_MFHI    = 6'h10;
  localparam logic [5:0] F_MFLO    = 6'h12;
  localparam logic [5:0] F_DIV     = 6'h1A;
  localparam logic [5:0] F_ADD     = 6'h20;
  localparam logic [5:0] F_ADDU    = 6'h21;
  localparam logic [5:0] F_SUB     = 6'h22;
  localparam logic [5:0] F_SUBU    = 6'h23;
  localparam logic [5:0] F_AND     = 6'h24;
  localparam logic [5:0] F_OR      = 6'h25;
  localparam logic [5:0] F_SLT     = 6'h2A;

  localparam logic [ALUOP_W-1:0] A_AND  = ALUOP_W'(5'b00000);
  localparam logic [ALUOP_W-1:0] A_OR   = ALUOP_W'(5'b00001);
  localparam logic [ALUOP_W-1:0] A_ADD  = ALUOP_W'(5'b00010);
  localparam logic [ALUOP_W-1:0] A_LUI  = ALUOP_W'(5'b00011);
  localparam logic [ALUOP_W-1:0] A_MFLO = ALUOP_W'(5'b00100);
  localparam logic [ALUOP_W-1:0] A_MFHI = ALUOP_W'(5'b00101);
  localparam logic [ALUOP_W-1:0] A_SUB  = ALUOP_W'(5'b00110);
  localparam logic [ALUOP_W-1:0] A_SLT  = ALUOP_W'(5'b00111);
  localparam logic [ALUOP_W-1:0] A_SLL  = ALUOP_W'(5'b01000);
  localparam logic [ALUOP_W-1:0] A_SRA  = ALUOP_W'(5'b01001);
  localparam logic [ALUOP_W-1:0] A_DIV  = ALUOP_W'(5'b01010);
  localparam logic [ALUOP_W-1:0] A_MOVZ = ALUOP_W'(5'b01101);

  typedef struct packed {
    logic               vld;
    logic               rdst;
    logic               asrc;
    logic [ALUOP_W-1:0] alu;
    logic [1:0]         mem;
    logic [1:0]         wb;
    logic               jump;
    logic               branch;
    logic               jr;
    logic               jal;
    logic               sys;
    logic [2:0]         bop;
    logic [1:0]         bw;
    logic               ill;
  } ctrl_t;

  typedef enum logic [1:0] {S_RUN, S_DIV, S_SYS, S_HALT} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [4:0]      lw_rt, lw_rt_d;
  ctrl_t           q, nxt, dec;

  logic [5:0] op, fn;
  logic [4:0] rs, rt;
  logic legal, is_lw, is_div, is_sys, is_brk, reads_rt;
  logic live, hazard, div_wait;

  assign op = instr[31:26];
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign fn = instr[5:0];

  always_comb begin
    dec      = '0;
    dec.vld  = 1'b1;
    legal    = 1'b1;
    is_lw    = 1'b0;
    is_div   = 1'b0;
    is_sys   = 1'b0;
    is_brk   = 1'b0;
    reads_rt = 1'b0;
    unique case (1'b1)
      op == OP_SPECIAL: begin
        reads_rt = 1'b1;
        dec.rdst = 1'b1;
        dec.wb   = 2'b10;
        unique case (1'b1)
          fn == F_AND:                 dec.alu = A_AND;
          fn == F_OR:                  dec.alu = A_OR;
          fn == F_ADD  || fn == F_ADDU: dec.alu = A_ADD;
          fn == F_SUB  || fn == F_SUBU: dec.alu = A_SUB;
          fn == F_MOVZ:                dec.alu = A_MOVZ;
          fn == F_MFLO:                dec.alu = A_MFLO;
          fn == F_MFHI:                dec.alu = A_MFHI;
          fn == F_SLT:                 dec.alu = A_SLT;
          fn == F_SRA:                 dec.alu = A_SRA;
          fn == F_SLL:                 dec.alu = A_SLL;
          fn == F_DIV: begin
            dec.alu = A_DIV;
            is_div  = 1'b1;
          end
          fn == F_JR: begin
            dec.rdst = 1'b0;
            dec.wb   = 2'b00;
            dec.jump = 1'b1;
            dec.jr   = 1'b1;
          end
          fn == F_SYSCALL: is_sys = 1'b1;
          fn == F_BREAK:   is_brk = 1'b1;
          default:         legal  = 1'b0;
        endcase
      end
      op == OP_LUI: begin
        dec.wb   = 2'b10;
        dec.asrc = 1'b1;
        dec.alu  = A_LUI;
      end
      op == OP_J: dec.jump = 1'b1;
      op == OP_JAL: begin
        dec.jump = 1'b1;
        dec.wb   = 2'b10;
        dec.jal  = 1'b1;
      end
      op == OP_ADDI || op == OP_ADDIU: begin
        dec.wb   = 2'b10;
        dec.asrc = 1'b1;
        dec.alu  = A_ADD;
      end
      op == OP_ANDI: begin
        dec.wb   = 2'b10;
        dec.asrc = 1'b1;
        dec.alu  = A_AND;
      end
      op == OP_ORI: begin
        dec.wb   = 2'b10;
        dec.asrc = 1'b1;
        dec.alu  = A_OR;
      end
      op == OP_BEQ: begin
        dec.branch = 1'b1;
        dec.bop    = 3'b001;
        reads_rt   = 1'b1;
      end
      op == OP_BNE: begin
        dec.branch = 1'b1;
        dec.bop    = 3'b100;
        reads_rt   = 1'b1;
      end
      op == OP_REGIMM: begin
        dec.branch = 1'b1;
        dec.bop    = 3'b110;
      end
      op == OP_LW: begin
        is_lw    = 1'b1;
        dec.mem  = 2'b01;
        dec.wb   = 2'b11;
        dec.asrc = 1'b1;
        dec.alu  = A_ADD;
      end
      op == OP_SW || op == OP_SB: begin
        reads_rt = 1'b1;
        dec.mem  = 2'b10;
        dec.asrc = 1'b1;
        dec.alu  = A_ADD;
        dec.bw   = (op == OP_SW) ? 2'b01 : 2'b10;
      end
      default: legal = 1'b0;
    endcase
  end

  assign live     = instr_valid && (instr != '0);
  assign div_wait = (state == S_DIV) && (cnt != '0);
  assign hazard   = live && (lw_rt != '0) &&
                    ((rs == lw_rt) || (reads_rt && rt == lw_rt));

  // DIV_BUSY with an expired counter behaves exactly like RUN.
  always_comb begin
    nxt     = '0;
    state_d = state;
    cnt_d   = cnt;
    lw_rt_d = '0;
    stall   = 1'b0;
    if (state == S_HALT) begin
      stall = 1'b1;
    end else if (flush) begin
      state_d = S_RUN;
      if (div_wait) begin
        state_d = S_DIV;
        cnt_d   = cnt - ONE;
      end
    end else if (div_wait) begin
      stall = 1'b1;
      cnt_d = cnt - ONE;
    end else if (state == S_SYS) begin
      if (cnt != '0) begin
        stall = 1'b1;
        cnt_d = cnt - ONE;
      end else begin
        nxt.vld  = 1'b1;
        nxt.rdst = 1'b1;
        nxt.wb   = 2'b10;
        nxt.sys  = 1'b1;
        state_d  = S_RUN;
      end
    end else begin
      state_d = S_RUN;
      if (hazard) begin
        stall = 1'b1;
      end else if (live) begin
        unique case (1'b1)
          !legal: nxt.ill = 1'b1;
          is_brk: state_d = S_HALT;
          is_sys: begin
            stall   = 1'b1;
            state_d = S_SYS;
            cnt_d   = SYS_LOAD;
          end
          default: begin
            nxt = dec;
            if (is_lw) lw_rt_d = rt;
            if (is_div) begin
              state_d = S_DIV;
              cnt_d   = DIV_LOAD;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RUN;
      cnt   <= '0;
      lw_rt <= '0;
      q     <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      lw_rt <= lw_rt_d;
      q     <= nxt;
    end
  end

  assign ctrl_valid      = q.vld;
  assign EX_D            = {q.rdst, q.asrc, q.alu};
  assign MEM_D           = q.mem;
  assign WB_D            = q.wb;
  assign Jump            = q.jump;
  assign Branch          = q.branch;
  assign jr_control      = q.jr;
  assign jal_control     = q.jal;
  assign syscall_control = q.sys;
  assign BranchOp        = q.bop;
  assign Byte_Warning    = q.bw;
  assign illegal         = q.ill;
  assign halt            = (state == S_HALT);

endmodule

// File: tb/tb_pipelined_control.sv
// tb_pipelined_control: directed and randomized checks of pipelined_control.
// Random traffic is compared against a cycle-level reference model.
module tb_pipelined_control;

  localparam int DIVC = 8;
  localparam int DRN  = 3;

  localparam int K_NORM = 0;
  localparam int K_LW   = 1;
  localparam int K_DIV  = 2;
  localparam int K_SYS  = 3;
  localparam int K_BRK  = 4;
  localparam int K_ILL  = 5;

  typedef struct packed {
    logic       vld;
    logic [6:0] ex;
    logic [1:0] mem;
    logic [1:0] wb;
    logic       jump;
    logic       branch;
    logic       jr;
    logic       jal;
    logic       sys;
    logic [2:0] bop;
    logic [1:0] bw;
    logic       ill;
  } word_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        flush;
  logic        stall, ctrl_valid;
  logic [6:0]  EX_D;
  logic [1:0]  MEM_D, WB_D;
  logic        Jump, Branch, jr_control, jal_control, syscall_control;
  logic [2:0]  BranchOp;
  logic [1:0]  Byte_Warning;
  logic        illegal, halt;

  int n_cmp, n_fail;

  int m_busy, m_drain, m_lwrt;
  bit m_halt;

  pipelined_control #(
    .ALUOP_W(5), .DIV_CYCLES(DIVC), .SYSCALL_DRAIN(DRN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .instr_valid(instr_valid), .flush(flush), .stall(stall),
    .ctrl_valid(ctrl_valid), .EX_D(EX_D), .MEM_D(MEM_D), .WB_D(WB_D),
    .Jump(Jump), .Branch(Branch), .jr_control(jr_control),
    .jal_control(jal_control), .syscall_control(syscall_control),
    .BranchOp(BranchOp), .Byte_Warning(Byte_Warning),
    .illegal(illegal), .halt(halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic word_t obs();
    return word_t'({ctrl_valid, EX_D, MEM_D, WB_D, Jump, Branch,
                    jr_control, jal_control, syscall_control,
                    BranchOp, Byte_Warning, illegal});
  endfunction

  function automatic word_t sys_word();
    word_t w;
    w = '0;
    w.vld = 1'b1;
    w.ex  = 7'b1000000;
    w.wb  = 2'b10;
    w.sys = 1'b1;
    return w;
  endfunction

  // Reference decode straight from the instruction table.
  function automatic word_t ref_word(input logic [31:0] i,
                                     output int kind, output bit rrt);
    word_t r;
    r = '0;
    r.vld = 1'b1;
    kind = K_NORM;
    rrt = 1'b0;
    case (i[31:26])
      6'h0F: begin r.wb = 2'b10; r.ex = 7'b0100011; end
      6'h02: r.jump = 1'b1;
      6'h03: begin r.jump = 1'b1; r.wb = 2'b10; r.jal = 1'b1; end
      6'h08, 6'h09: begin r.wb = 2'b10; r.ex = 7'b0100010; end
      6'h0C: begin r.wb = 2'b10; r.ex = 7'b0100000; end
      6'h0D: begin r.wb = 2'b10; r.ex = 7'b0100001; end
      6'h04: begin r.branch = 1'b1; r.bop = 3'b001; rrt = 1'b1; end
      6'h05: begin r.branch = 1'b1; r.bop = 3'b100; rrt = 1'b1; end
      6'h01: begin r.branch = 1'b1; r.bop = 3'b110; end
      6'h23: begin kind = K_LW; r.mem = 2'b01; r.wb = 2'b11; r.ex = 7'b0100010; end
      6'h2B: begin r.mem = 2'b10; r.ex = 7'b0100010; r.bw = 2'b01; rrt = 1'b1; end
      6'h28: begin r.mem = 2'b10; r.ex = 7'b0100010; r.bw = 2'b10; rrt = 1'b1; end
      6'h00: begin
        rrt = 1'b1;
        r.wb = 2'b10;
        case (i[5:0])
          6'h24: r.ex = 7'b1000000;
          6'h25: r.ex = 7'b1000001;
          6'h20, 6'h21: r.ex = 7'b1000010;
          6'h22, 6'h23: r.ex = 7'b1000110;
          6'h1A: begin r.ex = 7'b1001010; kind = K_DIV; end
          6'h0A: r.ex = 7'b1001101;
          6'h12: r.ex = 7'b1000100;
          6'h10: r.ex = 7'b1000101;
          6'h2A: r.ex = 7'b1000111;
          6'h03: r.ex = 7'b1001001;
          6'h00: r.ex = 7'b1001000;
          6'h08: begin r.wb = 2'b00; r.jump = 1'b1; r.jr = 1'b1; end
          6'h0C: kind = K_SYS;
          6'h0D: kind = K_BRK;
          default: kind = K_ILL;
        endcase
      end
      default: kind = K_ILL;
    endcase
    return r;
  endfunction

  // One clock of the reference: expected stall now, expected word after the edge.
  task automatic model_step(input logic [31:0] i, input logic v, input logic f,
                            output word_t w, output logic s);
    word_t d;
    int kind, rs_, rt_, nxt_lw;
    bit rrt, live, haz;
    w = '0;
    s = 1'b0;
    nxt_lw = 0;
    d = ref_word(i, kind, rrt);
    rs_ = int'(i[25:21]);
    rt_ = int'(i[20:16]);
    live = v && (i != 32'h0);
    haz = live && m_lwrt != 0 && (rs_ == m_lwrt || (rrt && rt_ == m_lwrt));
    if (m_halt) s = 1'b1;
    else if (f) begin
      if (m_busy > 0) m_busy--;
      m_drain = -1;
    end else if (m_busy > 0) begin
      s = 1'b1;
      m_busy--;
    end else if (m_drain > 0) begin
      s = 1'b1;
      m_drain--;
    end else if (m_drain == 0) begin
      w = sys_word();
      m_drain = -1;
    end else if (haz) s = 1'b1;
    else if (live) begin
      case (kind)
        K_ILL: w.ill = 1'b1;
        K_BRK: m_halt = 1'b1;
        K_SYS: begin s = 1'b1; m_drain = DRN - 1; end
        default: begin
          w = d;
          if (kind == K_LW) nxt_lw = rt_;
          if (kind == K_DIV) m_busy = DIVC - 1;
        end
      endcase
    end
    m_lwrt = nxt_lw;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cyc(input logic [31:0] i, input logic v, input logic f,
                     output logic st);
    instr = i;
    instr_valid = v;
    flush = f;
    #1 st = stall;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    instr = '0;
    instr_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_busy = 0;
    m_drain = -1;
    m_lwrt = 0;
    m_halt = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    instr = 32'h20420005;
    instr_valid = 1'b1;
    flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (obs() !== word_t'('0)) begin
      n_fail++; $display("FAIL reset_out: got %h want 0", obs());
    end
    n_cmp++;
    if (stall !== 1'b0 || halt !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall_halt: got %b%b want 00", stall, halt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_decode();
    logic [31:0] ins [20];
    logic [6:0]  ex [20];
    logic s;
    word_t w;
    ins = '{32'h20420005, 32'h3042000F, 32'h34420001, 32'h3C021234,
            32'h08000010, 32'h10220003, 32'hAC220004, 32'hA0220004,
            32'h14220001, 32'h0C000010, 32'h03E00008, 32'h04200002,
            32'h0043082A, 32'h00021843, 32'h00021080, 32'h00431022,
            32'h0043100A, 32'h00001010, 32'h00431025, 32'h00431024};
    ex  = '{7'b0100010, 7'b0100000, 7'b0100001, 7'b0100011,
            7'b0000000, 7'b0000000, 7'b0100010, 7'b0100010,
            7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000,
            7'b1000111, 7'b1001001, 7'b1001000, 7'b1000110,
            7'b1001101, 7'b1000101, 7'b1000001, 7'b1000000};
    do_reset();
    for (int k = 0; k < 20; k++) begin
      w = '0;
      w.vld = 1'b1;
      w.ex = ex[k];
      case (k)
        0, 1, 2, 3:   w.wb = 2'b10;
        4:            w.jump = 1'b1;
        5:            begin w.branch = 1'b1; w.bop = 3'b001; end
        6:            begin w.mem = 2'b10; w.bw = 2'b01; end
        7:            begin w.mem = 2'b10; w.bw = 2'b10; end
        8:            begin w.branch = 1'b1; w.bop = 3'b100; end
        9:            begin w.jump = 1'b1; w.wb = 2'b10; w.jal = 1'b1; end
        10:           begin w.jump = 1'b1; w.jr = 1'b1; end
        11:           begin w.branch = 1'b1; w.bop = 3'b110; end
        default:      w.wb = 2'b10;
      endcase
      cyc(ins[k], 1'b1, 1'b0, s);
      n_cmp++;
      if (obs() !== w || s !== 1'b0) begin
        n_fail++;
        $display("FAIL decode[%0d] %h: got %h stall %b want %h stall 0",
                 k, ins[k], obs(), s, w);
      end
    end
    cyc(32'h20420005, 1'b0, 1'b0, s);
    n_cmp++;
    if (obs() !== word_t'('0)) begin
      n_fail++; $display("FAIL invalid_bubble: got %h want 0", obs());
    end
    cyc(32'h0, 1'b1, 1'b0, s);
    n_cmp++;
    if (obs() !== word_t'('0)) begin
      n_fail++; $display("FAIL nop_bubble: got %h want 0", obs());
    end
  endtask

  task automatic test_load_use();
    logic s;
    word_t lw, add;
    lw = '0; lw.vld = 1'b1; lw.ex = 7'b0100010; lw.mem = 2'b01; lw.wb = 2'b11;
    add = '0; add.vld = 1'b1; add.ex = 7'b1000010; add.wb = 2'b10;
    do_reset();
    cyc(32'h8C220000, 1'b1, 1'b0, s);
    n_cmp++;
    if (obs() !== lw || s !== 1'b0) begin
      n_fail++; $display("FAIL lw_issue: got %h stall %b want %h stall 0", obs(), s, lw);
    end
    cyc(32'h00441820, 1'b1, 1'b0, s);
    n_cmp++;
    if (obs() !== word_t'('0) || s !== 1'b1) begin
      n_fail++; $display("FAIL lu_bubble: got %h stall %b want 0 stall 1", obs(), s);
    end
    cyc(32'h00441820, 1'b1, 1'b0, s);
    n_cmp++;
    if (obs() !== add || s !== 1'b0) begin
      n_fail++; $display("FAIL lu_add: got %h stall %b want %h stall 0", obs(), s, add);
    end
    cyc(32'h8C220000, 1'b1, 1'b0, s);
    cyc(32'h20220001, 1'b1, 1'b0, s);
    n_cmp++;
    if (s !== 1'b0 || EX_D !== 7'b0100010) begin
      n_fail++; $display("FAIL lu_nohaz: got stall %b ex %b want 0 0100010", s, EX_D);
    end
    cyc(32'h8C220000, 1'b1, 1'b0, s);
    cyc(32'hAC220004, 1'b1, 1'b0, s);
    n_cmp++;
    if (s !== 1'b1) begin
      n_fail++; $display("FAIL lu_sw_rt: got stall %b want 1", s);
    end
    cyc(32'hAC220004, 1'b1, 1'b0, s);
    cyc(32'h8C220000, 1'b1, 1'b0, s);
    cyc(32'h00441820, 1'b1, 1'b1, s);
    n_cmp++;
    if (obs() !== word_t'('0) || s !== 1'b0) begin
      n_fail++; $display("FAIL lu_flush: got %h stall %b want 0 stall 0", obs(), s);
    end
    cyc(32'h00441820, 1'b1, 1'b0, s);
    n_cmp++;
    if (obs() !== add || s !== 1'b0) begin
      n_fail++; $display("FAIL lu_after_flush: got %h stall %b want %h", obs(), s, add);
    end
  endtask

  task automatic test_div();
    logic s;
    int stalls;
    word_t w;
    do_reset();
    cyc(32'h0085001A, 1'b1, 1'b0, s);
    w = '0; w.vld = 1'b1; w.ex = 7'b1001010; w.wb = 2'b10;
    n_cmp++;
    if (obs() !== w || s !== 1'b0) begin
      n_fail++; $display("FAIL div_issue: got %h stall %b want %h", obs(), s, w);
    end
    stalls = 0;
    for (int k = 0; k < 20 && s !== 1'b0 || k == 0; k++) begin
      cyc(32'h00001012, 1'b1, 1'b0, s);
      if (s === 1'b1) stalls++;
    end
    n_cmp++;
    if (stalls != DIVC - 1) begin
      n_fail++; $display("FAIL div_stalls: got %0d want %0d", stalls, DIVC - 1);
    end
    w.ex = 7'b1000100;
    n_cmp++;
    if (obs() !== w) begin
      n_fail++; $display("FAIL div_mflo: got %h want %h", obs(), w);
    end
  endtask

  task automatic test_reset_mid_div();
    logic s;
    word_t w;
    do_reset();
    cyc(32'h0085001A, 1'b1, 1'b0, s);
    cyc(32'h00001012, 1'b1, 1'b0, s);
    cyc(32'h00001012, 1'b1, 1'b0, s);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== word_t'('0) || stall !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_div: got %h stall %b want 0 stall 0", obs(), stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_busy = 0; m_drain = -1; m_lwrt = 0; m_halt = 1'b0;
    cyc(32'h00851021, 1'b1, 1'b0, s);
    w = '0; w.vld = 1'b1; w.ex = 7'b1000010; w.wb = 2'b10;
    n_cmp++;
    if (obs() !== w || s !== 1'b0) begin
      n_fail++; $display("FAIL rst_addu: got %h stall %b want %h", obs(), s, w);
    end
  endtask

  task automatic test_syscall();
    logic s;
    int bub;
    do_reset();
    bub = 0;
    for (int k = 0; k < DRN; k++) begin
      cyc(32'h0000000C, 1'b1, 1'b0, s);
      if (s === 1'b1 && obs() === word_t'('0)) bub++;
    end
    n_cmp++;
    if (bub != DRN) begin
      n_fail++; $display("FAIL sys_bubbles: got %0d want %0d", bub, DRN);
    end
    cyc(32'h0000000C, 1'b1, 1'b0, s);
    n_cmp++;
    if (obs() !== sys_word() || s !== 1'b0) begin
      n_fail++; $display("FAIL sys_word: got %h stall %b want %h", obs(), s, sys_word());
    end
    do_reset();
    cyc(32'h0000000C, 1'b1, 1'b0, s);
    cyc(32'h0000000C, 1'b1, 1'b0, s);
    cyc(32'h0000000C, 1'b1, 1'b1, s);
    n_cmp++;
    if (s !== 1'b0 || obs() !== word_t'('0)) begin
      n_fail++; $display("FAIL sys_flush: got %h stall %b want 0 stall 0", obs(), s);
    end
    cyc(32'h20420005, 1'b1, 1'b0, s);
    n_cmp++;
    if (syscall_control !== 1'b0 || EX_D !== 7'b0100010 || s !== 1'b0) begin
      n_fail++; $display("FAIL sys_flush_run: got sys %b ex %b want 0 0100010",
                         syscall_control, EX_D);
    end
  endtask

  task automatic test_illegal();
    logic s;
    word_t w;
    w = '0; w.ill = 1'b1;
    do_reset();
    cyc(32'hFC000000, 1'b1, 1'b0, s);
    n_cmp++;
    if (obs() !== w) begin
      n_fail++; $display("FAIL ill_op: got %h want %h", obs(), w);
    end
    cyc(32'h00000000, 1'b1, 1'b0, s);
    n_cmp++;
    if (illegal !== 1'b0) begin
      n_fail++; $display("FAIL ill_pulse: got %b want 0", illegal);
    end
    cyc(32'h00430801, 1'b1, 1'b0, s);
    n_cmp++;
    if (obs() !== w) begin
      n_fail++; $display("FAIL ill_fn: got %h want %h", obs(), w);
    end
  endtask

  task automatic test_break();
    logic s;
    do_reset();
    cyc(32'h0000000D, 1'b1, 1'b0, s);
    n_cmp++;
    if (halt !== 1'b1 || obs() !== word_t'('0)) begin
      n_fail++; $display("FAIL brk: got halt %b out %h want 1 0", halt, obs());
    end
    cyc(32'h20420005, 1'b1, 1'b0, s);
    n_cmp++;
    if (s !== 1'b1 || obs() !== word_t'('0) || halt !== 1'b1) begin
      n_fail++; $display("FAIL brk_hold: got stall %b out %h halt %b", s, obs(), halt);
    end
    cyc(32'h20420005, 1'b1, 1'b1, s);
    n_cmp++;
    if (s !== 1'b1 || obs() !== word_t'('0)) begin
      n_fail++; $display("FAIL brk_flush: got stall %b out %h want 1 0", s, obs());
    end
    do_reset();
    cyc(32'h20420005, 1'b1, 1'b0, s);
    n_cmp++;
    if (halt !== 1'b0 || EX_D !== 7'b0100010 || s !== 1'b0) begin
      n_fail++; $display("FAIL brk_reset: got halt %b ex %b want 0 0100010", halt, EX_D);
    end
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    logic [5:0] fns [14];
    logic [5:0] ops [13];
    int sel;
    fns = '{6'h24, 6'h25, 6'h20, 6'h21, 6'h22, 6'h23, 6'h1A,
            6'h0A, 6'h12, 6'h10, 6'h2A, 6'h03, 6'h08, 6'h01};
    ops = '{6'h0F, 6'h02, 6'h03, 6'h08, 6'h09, 6'h0C, 6'h0D,
            6'h04, 6'h05, 6'h01, 6'h23, 6'h2B, 6'h28};
    r = $urandom;
    r[25:21] = 5'($urandom_range(0, 4));
    r[20:16] = 5'($urandom_range(0, 4));
    sel = $urandom_range(0, 19);
    if (sel < 13) r[31:26] = ops[sel];
    else if (sel < 18) begin
      r[31:26] = 6'h00;
      r[5:0] = fns[$urandom_range(0, 13)];
    end else if (sel == 18) r[31:26] = 6'h3F;
    else r = 32'h0;
    return r;
  endfunction

  task automatic test_random();
    logic [31:0] cur;
    logic v, f, s, ms;
    word_t mw;
    do_reset();
    cur = rnd_instr();
    v = 1'b1;
    for (int c = 0; c < 600; c++) begin
      f = ($urandom_range(0, 9) == 0);
      model_step(cur, v, f, mw, ms);
      cyc(cur, v, f, s);
      n_cmp++;
      if (s !== ms) begin
        n_fail++; $display("FAIL rnd_stall[%0d] %h: got %b want %b", c, cur, s, ms);
      end
      n_cmp++;
      if (obs() !== mw) begin
        n_fail++; $display("FAIL rnd_out[%0d] %h: got %h want %h", c, cur, obs(), mw);
      end
      if (!ms) begin
        cur = rnd_instr();
        v = ($urandom_range(0, 7) != 0);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    m_busy = 0; m_drain = -1; m_lwrt = 0; m_halt = 1'b0;
    test_reset();
    test_decode();
    test_load_use();
    test_div();
    test_reset_mid_div();
    test_syscall();
    test_illegal();
    test_random();
    test_break();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_control.md
Name: pipelined_control

Overview:
- Registered, stall-aware successor to the combinational MIPS control decoder.
- Sits between IF/ID and ID/EX. Decodes the instruction into the same EX/MEM/WB control bundles.
- Adds four sequential behaviours: load-use bubble insertion, a multi-cycle DIV busy stall, a SYSCALL pipeline-drain sequence, and a sticky BREAK halt.
- An illegal opcode raises a flag and issues a bubble instead of printing a message.

Parameters:
- ALUOP_W, 5, ALU op field width; EX_D width is ALUOP_W+2.
- DIV_CYCLES, 8, total DIV occupancy in cycles (>=2).
- SYSCALL_DRAIN, 3, bubble cycles emitted before the syscall control word (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- instr  in  32  instruction from IF/ID.
- instr_valid  in  1  instr holds a real instruction.
- flush  in  1  squash the instruction in decode (taken branch/jump).
- stall  out  1  combinational; upstream holds instr and PC while 1.
- ctrl_valid  out  1  registered; control outputs carry an issued instruction.
- EX_D  out  ALUOP_W+2  {RegDst, ALUsrc, ALUop}.
- MEM_D  out  2  {MemWrite, MemRead}.
- WB_D  out  2  {RegWrite, MemToReg}.
- Jump, Branch, jr_control, jal_control, syscall_control  out  1 each.
- BranchOp  out  3  branch condition.
- Byte_Warning  out  2  00 LW, 01 SW, 10 SB, 00 otherwise.
- illegal  out  1  one-cycle pulse on an undecodable instruction.
- halt  out  1  sticky after BREAK.

Behaviour:
- Reset: all outputs 0 and state RUN. The load-use tracker is cleared. Asynchronous assertion is allowed mid-DIV or mid-drain and aborts the operation.
- Latency: 1 cycle. An instruction accepted at edge N drives the outputs after edge N with ctrl_valid=1.
- Bubble: all control outputs 0 and ctrl_valid=0. A bubble is issued for: instr_valid=0; instr==0 (NOP); flush; a hazard; DIV_BUSY; SYS_DRAIN; HALT.
- Decode, I-type:
  - LUI: RegWrite, ALUsrc, ALUop 00011.
  - J: Jump.
  - JAL: Jump, RegWrite, jal_control.
  - ADDI/ADDIU: RegWrite, ALUsrc, ALUop 00010.
  - ANDI: RegWrite, ALUsrc, ALUop 00000.
  - ORI: RegWrite, ALUsrc, ALUop 00001.
  - BEQ: Branch, BranchOp 001. BNE: Branch, BranchOp 100. REGIMM (BLTZ): Branch, BranchOp 110.
  - LW: MemRead, MemToReg, RegWrite, ALUsrc, ALUop 00010.
  - SW and SB: MemWrite, ALUsrc, ALUop 00010.
- Decode, SPECIAL (RegDst=1, RegWrite=1):
  - AND 00000, OR 00001, ADD/ADDU 00010, SUB/SUBU 00110.
  - DIV 01010, MOVZ 01101, MFLO 00100, MFHI 00101, SLT 00111, SRA 01001.
  - SLL (nonzero instr) 01000.
  - JR: Jump, jr_control, RegWrite=0.
- Any other opcode or funct: bubble plus illegal=1 for one cycle.
- Opcode and funct encodings come from mips.h.
- State machine (RUN, DIV_BUSY, SYS_DRAIN, HALT):
  - RUN, accepting DIV: DIV's control word issues immediately. Counter loads DIV_CYCLES-1, then DIV_BUSY. stall=1 in DIV_BUSY; the counter decrements each cycle. At 0, return to RUN with stall=0 that cycle. flush does not abort DIV_BUSY.
  - RUN, accepting SYSCALL: stall=1, emit SYSCALL_DRAIN bubbles in SYS_DRAIN. The next edge then issues syscall_control=1, RegDst=1, RegWrite=1, ctrl_valid=1. stall drops in the cycle of that edge, and the block returns to RUN.
  - flush during SYS_DRAIN: return to RUN, no syscall issued.
  - RUN, accepting BREAK: bubble issued, HALT entered, halt=1, stall=1 permanently until reset.
- Load-use hazard (RUN only):
  - Condition: the previous issued instruction was LW with rt_p!=0, and either rs==rt_p, or rt==rt_p where the current instruction reads rt (SPECIAL, BEQ, BNE, SW, SB).
  - Response: stall=1 for exactly one cycle and one bubble, then issue. The tracker clears after a bubble and on flush.
- Priority: reset > HALT > flush > DIV_BUSY/SYS_DRAIN > hazard > normal decode.
- flush during a hazard stall squashes the instruction and drops stall.

Test Plan:
- Reset mid-DIV: rst_n low at busy cycle 3 -> all outputs 0 and stall=0 after release; next ADDU 0x00851021 decodes normally.
- ADDI 0x20420005 -> next cycle ctrl_valid=1, EX_D=0b0100010, WB_D=10, MEM_D=00. ANDI 0x3042000F -> EX_D=0b0100000, WB_D=10.
- LW $2,0($1) (0x8C220000) followed by ADD $3,$2,$4 (0x00441820) -> stall=1 for one cycle, one bubble, then ADD issues with EX_D=0b1000010.
- DIV (0x0085001A) with DIV_CYCLES=8 -> DIV word issues, stall=1 for 7 cycles, a waiting MFLO issues after.
- SYSCALL (0x0000000C) with SYSCALL_DRAIN=3 -> 3 bubbles, then syscall_control=1, WB_D=10. Variant: flush in bubble 2 -> no syscall, RUN.
- Opcode 0x3F -> illegal pulse, bubble. BREAK (0x0000000D) -> halt=1, stall=1 sticky; further instructions ignored until rst_n.
